// File: rtl/configs_loader.sv
// rtl/configs_loader.sv - streamed configuration loader with XOR checksum and atomic commit
module configs_loader #(
    parameter int DATA_W    = 32,
    parameter int NUM_WORDS = 24,
    parameter int ADDR_W    = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        io_start,
    input  logic                        io_d_in_valid,
    output logic                        io_d_in_ready,
    input  logic [DATA_W-1:0]           io_d_in,
    input  logic [ADDR_W-1:0]           io_rd_addr,
    output logic [DATA_W-1:0]           io_rd_data,
    output logic                        io_busy,
    output logic                        io_done,
    output logic                        io_error,
    output logic [DATA_W*NUM_WORDS-1:0] io_configs_out
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CSUM = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0]   accum_q, accum_d;
    logic [DATA_W-1:0]   shadow_q [NUM_WORDS];
    logic [DATA_W-1:0]   shadow_d [NUM_WORDS];
    logic [DATA_W-1:0]   active_q [NUM_WORDS];
    logic [DATA_W-1:0]   active_d [NUM_WORDS];
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                accept;

    assign io_busy       = (state_q != IDLE);
    assign io_d_in_ready = (state_q != IDLE) && !io_start;
    assign accept        = io_d_in_valid && io_d_in_ready;
    assign io_rd_data    = rd_data_q;
    assign io_done       = done_q;
    assign io_error      = error_q;

    for (genvar i = 0; i < NUM_WORDS; i++) begin : g_pack
        assign io_configs_out[DATA_W*i +: DATA_W] = active_q[i];
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        accum_d   = accum_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        done_d    = 1'b0;
        error_d   = error_q;
        rd_data_d = (io_rd_addr <= LAST_PTR) ? active_q[io_rd_addr] : '0;

        // io_start restarts from any state; the word offered alongside it is dropped
        if (io_start) begin
            state_d = LOAD;
            ptr_d   = '0;
            accum_d = '0;
            error_d = 1'b0;
        end else if (accept) begin
            case (state_q)
                LOAD: begin
                    shadow_d[ptr_q] = io_d_in;
                    accum_d         = accum_q ^ io_d_in;
                    if (ptr_q == LAST_PTR) begin
                        state_d = CSUM;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
                CSUM: begin
                    state_d = IDLE;
                    if (io_d_in == accum_q) begin
                        active_d = shadow_q;
                        done_d   = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            accum_q   <= '0;
            rd_data_q <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            accum_q   <= accum_d;
            rd_data_q <= rd_data_d;
            done_q    <= done_d;
            error_q   <= error_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
        end
    end

endmodule

// File: tb/tb_configs_loader.sv
// tb/tb_configs_loader.sv - randomized self-checking bench for configs_loader
module tb_configs_loader;
    localparam int DW  = 32;
    localparam int NW  = 24;
    localparam int AW  = 5;
    localparam int TOT = DW * NW;

    logic           clk = 1'b0;
    logic           clk_en = 1'b0;
    logic           reset = 1'b1;
    logic           io_start = 1'b0;
    logic           io_d_in_valid = 1'b0;
    logic           io_d_in_ready;
    logic [DW-1:0]  io_d_in = '0;
    logic [AW-1:0]  io_rd_addr = '0;
    logic [DW-1:0]  io_rd_data;
    logic           io_busy;
    logic           io_done;
    logic           io_error;
    logic [TOT-1:0] io_configs_out;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;
    bit rand_rd = 1'b0;
    int stall_pct = 0;

    configs_loader #(.DATA_W(DW), .NUM_WORDS(NW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .io_start(io_start),
        .io_d_in_valid(io_d_in_valid), .io_d_in_ready(io_d_in_ready), .io_d_in(io_d_in),
        .io_rd_addr(io_rd_addr), .io_rd_data(io_rd_data), .io_busy(io_busy),
        .io_done(io_done), .io_error(io_error), .io_configs_out(io_configs_out)
    );

    always #5 if (clk_en) clk = ~clk;

    task automatic chk(input string nm, input logic [TOT-1:0] act, input logic [TOT-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: a load is the list of words received since io_start;
    // the word after NW data words is the checksum.
    bit            m_busy = 1'b0;
    bit            m_done = 1'b0;
    bit            m_err = 1'b0;
    logic [DW-1:0] m_rd = '0;
    logic [DW-1:0] m_active [NW];
    logic [DW-1:0] m_words [$];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_rd = '0;
            m_words.delete();
            for (int i = 0; i < NW; i++) m_active[i] = '0;
        end else begin
            logic [DW-1:0] x;
            m_rd = (int'(io_rd_addr) < NW) ? m_active[io_rd_addr] : '0;
            m_done = 1'b0;
            if (io_start) begin
                m_busy = 1'b1;
                m_err = 1'b0;
                m_words.delete();
            end else if (m_busy && io_d_in_valid) begin
                if (m_words.size() < NW) begin
                    m_words.push_back(io_d_in);
                end else begin
                    x = '0;
                    foreach (m_words[i]) x = x ^ m_words[i];
                    if (x == io_d_in) begin
                        for (int i = 0; i < NW; i++) m_active[i] = m_words[i];
                        m_done = 1'b1;
                    end else begin
                        m_err = 1'b1;
                    end
                    m_busy = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [TOT-1:0] exp_cfg;
            for (int i = 0; i < NW; i++) exp_cfg[i*DW +: DW] = m_active[i];
            chk("busy", io_busy, m_busy);
            chk("ready", io_d_in_ready, m_busy && !io_start);
            chk("done", io_done, m_done);
            chk("error", io_error, m_err);
            chk("rd_data", io_rd_data, m_rd);
            chk("configs_out", io_configs_out, exp_cfg);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #2;
        if (rand_rd) io_rd_addr = AW'($urandom_range(0, 31));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    task automatic start(input bit with_valid);
        io_start = 1'b1;
        io_d_in_valid = with_valid;
        io_d_in = $urandom;
        next_cycle();
        io_start = 1'b0;
        io_d_in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [DW-1:0] w);
        int n;
        bit acc;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 300) begin
            io_d_in_valid = ($urandom_range(0, 99) >= stall_pct);
            io_d_in = io_d_in_valid ? w : $urandom;
            @(negedge clk);
            acc = io_d_in_valid && io_d_in_ready;
            next_cycle();
            io_d_in_valid = 1'b0;
            n++;
        end
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic load_seq(input int nwords);
        start(1'b0);
        for (int i = 0; i < nwords; i++) send_word(DW'(i + 1));
    endtask

    logic [TOT-1:0] seq_cfg;
    logic [TOT-1:0] a5_cfg;
    logic [DW-1:0]  rw [NW];
    logic [DW-1:0]  x;

    initial begin
        for (int i = 0; i < NW; i++) begin
            seq_cfg[i*DW +: DW] = DW'(i + 1);
            a5_cfg[i*DW +: DW] = 32'hA5A5A5A5;
        end

        // 1: asynchronous reset without any clock edge
        #1 reset = 1'b0;
        #2;
        chk("rst_configs", io_configs_out, '0);
        chk("rst_busy", io_busy, 0);
        chk("rst_ready", io_d_in_ready, 0);
        chk("rst_done", io_done, 0);
        chk("rst_error", io_error, 0);
        chk("rst_rd_data", io_rd_data, 0);
        clk_en = 1'b1;
        chk_en = 1'b1;
        next_cycle();
        reset = 1'b1;
        idle(2);

        // 2: good load, no stalls
        stall_pct = 0;
        io_rd_addr = 5'd23;
        load_seq(NW);
        send_word(32'h18);
        chk("s2_done", io_done, 1);
        chk("s2_busy", io_busy, 0);
        chk("s2_word0", io_configs_out[31:0], 32'h1);
        chk("s2_word23", io_configs_out[767:736], 32'h18);
        next_cycle();
        chk("s2_done_once", io_done, 0);
        chk("s2_rd23", io_rd_data, 32'h18);

        // 3: bad checksum
        load_seq(NW);
        send_word(32'h19);
        chk("s3_error", io_error, 1);
        chk("s3_no_done", io_done, 0);
        idle(3);
        chk("s3_error_sticky", io_error, 1);
        chk("s3_configs_kept", io_configs_out, seq_cfg);

        // 4: random stalls
        stall_pct = 50;
        load_seq(NW);
        send_word(32'h18);
        chk("s4_error_clr", io_error, 0);
        chk("s4_configs", io_configs_out, seq_cfg);

        // 5: abort and restart, the word offered with the second io_start is dropped
        stall_pct = 0;
        start(1'b0);
        for (int i = 0; i < 10; i++) send_word(32'hDEADBEEF);
        start(1'b1);
        for (int i = 0; i < NW; i++) send_word(32'hA5A5A5A5);
        send_word(32'h0);
        chk("s5_configs", io_configs_out, a5_cfg);
        chk("s5_error", io_error, 0);

        // 6: asynchronous reset between edges during word 7
        rand_rd = 1'b1;
        load_seq(6);
        io_d_in_valid = 1'b1;
        io_d_in = 32'h7;
        #1 reset = 1'b0;
        #1;
        chk("s6_configs_zero", io_configs_out, '0);
        chk("s6_busy", io_busy, 0);
        next_cycle();
        io_d_in_valid = 1'b0;
        reset = 1'b1;
        stall_pct = 30;
        load_seq(NW);
        send_word(32'h18);
        chk("s6_reload", io_configs_out, seq_cfg);

        // randomized loads: valid noise while idle, aborts, good and bad checksums
        for (int r = 0; r < 8; r++) begin
            stall_pct = $urandom_range(0, 70);
            io_d_in_valid = 1'b1;
            io_d_in = $urandom;
            idle($urandom_range(1, 3));
            io_d_in_valid = 1'b0;
            start(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < int'($urandom_range(1, NW)); i++) send_word($urandom);
                start(1'($urandom_range(0, 1)));
            end
            x = '0;
            for (int i = 0; i < NW; i++) begin
                rw[i] = $urandom;
                x = x ^ rw[i];
                send_word(rw[i]);
            end
            if ($urandom_range(0, 2) == 0) send_word(x ^ ($urandom | 32'h1));
            else send_word(x);
            idle($urandom_range(0, 4));
        end

        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/configs_loader.md
Name: configs_loader

Overview:
Parametrised successor to the fixed 24x32 configuration latch bank. It accepts a stream of configuration words over a valid/ready handshake and writes them to a shadow register file with an auto-incrementing word pointer. A trailing XOR checksum word is then verified. Only on a match is the shadow copied atomically into the active configuration that drives the tile fabric; the active configuration can also be read back one word at a time.

Parameters:
DATA_W, 32, width of one configuration word.
NUM_WORDS, 24, number of configuration words (NUM_WORDS >= 2).
ADDR_W, 5, word pointer / readback address width (>= clog2(NUM_WORDS)).

Ports:
clk  in  1  single clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-low reset (asserted when 0).
io_start  in  1  single-cycle pulse: begin a new load at word 0.
io_d_in_valid  in  1  io_d_in holds a word.
io_d_in_ready  out  1  loader accepts a word this cycle.
io_d_in  in  DATA_W  config data word or checksum word.
io_rd_addr  in  ADDR_W  readback word index.
io_rd_data  out  DATA_W  registered readback of active word io_rd_addr.
io_busy  out  1  a load is in progress.
io_done  out  1  one-cycle pulse: successful commit.
io_error  out  1  sticky checksum-mismatch flag.
io_configs_out  out  DATA_W*NUM_WORDS  active configuration; word i occupies bits [DATA_W*(i+1)-1 : DATA_W*i].

Behaviour:
- Reset (reset=0, asynchronous, no clock needed):
  - state=IDLE; ptr=0; accum=0.
  - shadow, active, io_rd_data = 0.
  - io_done=0, io_error=0.
  - All outputs are at these values immediately. Reset mid-load discards the load; active is zeroed.
- State machine: IDLE, LOAD, CSUM.
  - io_busy = (state != IDLE).
  - io_d_in_ready = (state != IDLE) && !io_start.
  - A word is accepted when io_d_in_valid && io_d_in_ready at a rising edge.
- IDLE:
  - io_start -> LOAD; ptr=0; accum=0; io_error cleared.
  - io_d_in_valid is ignored.
- LOAD, on each accepted word:
  - shadow[ptr] <= io_d_in; accum <= accum ^ io_d_in.
  - If ptr == NUM_WORDS-1: go to CSUM. Otherwise ptr <= ptr+1.
  - With valid low, hold everything; stalls of any length are allowed.
- CSUM, on the accepted word:
  - Match (word == accum): active <= shadow on that edge; io_done=1 for exactly the next cycle; go to IDLE.
  - Mismatch: active unchanged; io_error <= 1 (held until the next io_start or reset); no io_done; go to IDLE.
- io_start while in LOAD or CSUM is an abort-and-restart:
  - Any word presented that cycle is not accepted.
  - ptr=0, accum=0, io_error=0; state stays/returns to LOAD.
  - Shadow contents are simply overwritten; active is untouched.
- Active configuration stability:
  - io_configs_out changes only on a successful commit edge or on reset.
  - It never shows a partially loaded configuration.
- Readback:
  - io_rd_data <= active[io_rd_addr] every edge (1-cycle latency).
  - io_rd_addr >= NUM_WORDS yields 0.
  - Readback during the commit edge returns the pre-commit value; the new value appears one cycle later.
- Pointer and XOR widths:
  - The pointer never wraps past NUM_WORDS-1.
  - The XOR accumulator is DATA_W bits with no carries.

Test Plan:
1. Reset check: hold reset=0 with no clock edges -> io_configs_out=0, io_busy=0, io_d_in_ready=0, io_done=0, io_error=0, io_rd_data=0.
2. Good load, no stalls: io_start, then words 0x1..0x18, then checksum 0x18 -> io_done high one cycle after the checksum edge; io_configs_out[31:0]=0x1 and [767:736]=0x18; io_busy=0; io_rd_addr=23 gives io_rd_data=0x18 one cycle later.
3. Bad checksum: repeat scenario 2's load with data words 0x1..0x18, but send checksum 0x19 -> io_error=1 and stays 1; no io_done; io_configs_out retains the previous values.
4. Random valid stalls: scenario 2 with io_d_in_valid low on about 50% of cycles -> identical final io_configs_out; io_d_in_ready held high throughout LOAD/CSUM.
5. Abort and restart:
   - io_start, 10 words of 0xDEADBEEF, then io_start again with valid high (word dropped).
   - Then 24 words of 0xA5A5A5A5 and checksum 0x00000000.
   - Expected: commit succeeds; every word = 0xA5A5A5A5; io_error cleared.
6. Async reset mid-load: after a committed load, assert reset between edges during word 7 of a new load -> io_configs_out=0 immediately; state IDLE; a subsequent full load commits correctly.
